// File: rtl/seq_pkg.sv
// seq_pkg: shared opcode/state types, instruction field positions and opcode classes
package seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_NOT  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_SRA  = 4'h4,
    OP_SLL  = 4'h5,
    OP_BEQZ = 4'h6,
    OP_BNEZ = 4'h7,
    OP_XOR  = 4'h8,
    OP_ADDI = 4'h9,
    OP_LI   = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_HALTED} state_e;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  function automatic logic is_write(input opcode_e op);
    return op inside {OP_ADD, OP_NOT, OP_AND, OP_OR, OP_SRA, OP_SLL, OP_XOR, OP_ADDI, OP_LI};
  endfunction
  function automatic logic is_branch(input opcode_e op);
    return op inside {OP_BEQZ, OP_BNEZ};
  endfunction
endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational decode of the instruction register into datapath controls
//   ir                          : latched instruction word
//   alu_op, alu_src1, alu_src2  : ALU opcode and operand-source selects
//   imm_out                     : sign-extended imm6
//   rd0_addr, rd1_addr, wr_addr : register-file addresses (rs1, rs2, rd)
//   wr_cls, br_cls, ill_cls, halt_cls : instruction class flags
module seq_decode
  import seq_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  alu_op,
  output logic        alu_src1,
  output logic        alu_src2,
  output logic [15:0] imm_out,
  output logic [2:0]  rd0_addr,
  output logic [2:0]  rd1_addr,
  output logic [2:0]  wr_addr,
  output logic        wr_cls,
  output logic        br_cls,
  output logic        ill_cls,
  output logic        halt_cls
);
  opcode_e op;
  assign op = opcode_e'(ir[OP_MSB:OP_LSB]);
  always_comb begin
    wr_cls   = is_write(op);
    br_cls   = is_branch(op);
    halt_cls = op == OP_HALT;
    ill_cls  = !(wr_cls || br_cls || halt_cls);
    alu_src1 = op == OP_LI;
    alu_src2 = op == OP_ADDI || op == OP_LI;
    alu_op   = alu_src2 ? 4'(OP_ADD) : ir[OP_MSB:OP_LSB];
    imm_out  = {{(16 - (IMM_MSB - IMM_LSB + 1)){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
    rd0_addr = ir[RS1_MSB:RS1_LSB];
    rd1_addr = ir[RS2_MSB:RS2_LSB];
    wr_addr  = ir[RD_MSB:RD_LSB];
  end
endmodule

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: multi-cycle FSM sequencing the ALU/register-file datapath
//   instr_valid/instr_ready/instr : one-at-a-time instruction handshake
//   alu_result, alu_ovf, take_branch : datapath feedback, captured in EXEC
//   rd0_addr, rd1_addr, wr_addr, alu_op, alu_src1, alu_src2, imm_out : decoded controls
//   wr_en, wr_data : register write strobe and data (WB state)
//   pc, retired    : program counter and retired-instruction count
//   busy, halted, ovf_flag, illegal : status
module alu_exec_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  input  logic [15:0]     alu_result,
  input  logic            alu_ovf,
  input  logic            take_branch,
  output logic [2:0]      rd0_addr,
  output logic [2:0]      rd1_addr,
  output logic [2:0]      wr_addr,
  output logic [3:0]      alu_op,
  output logic            alu_src1,
  output logic            alu_src2,
  output logic [15:0]     imm_out,
  output logic            wr_en,
  output logic [15:0]     wr_data,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            ovf_flag,
  output logic            illegal,
  output logic [15:0]     retired
);
  state_e state, state_nx;
  logic [15:0] ir, res_q;
  logic wr_cls, br_cls, ill_cls, halt_cls;
  logic in_exec, pc_inc, pc_jmp, retire, add_cls;
  seq_decode u_dec (
    .ir       (ir),
    .alu_op   (alu_op),
    .alu_src1 (alu_src1),
    .alu_src2 (alu_src2),
    .imm_out  (imm_out),
    .rd0_addr (rd0_addr),
    .rd1_addr (rd1_addr),
    .wr_addr  (wr_addr),
    .wr_cls   (wr_cls),
    .br_cls   (br_cls),
    .ill_cls  (ill_cls),
    .halt_cls (halt_cls)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == S_IDLE   ? (instr_valid ? S_DECODE : S_IDLE) :
               state == S_DECODE ? S_EXEC :
               state == S_EXEC   ? (wr_cls ? S_WB : halt_cls ? S_HALTED : S_IDLE) :
               state == S_HALTED ? S_HALTED : S_IDLE;
  end
  always_comb begin
    instr_ready = state == S_IDLE;
    busy        = state inside {S_DECODE, S_EXEC, S_WB};
    halted      = state == S_HALTED;
    wr_en       = state == S_WB;
    wr_data     = res_q;
  end
  always_comb begin
    in_exec = state == S_EXEC;
    add_cls = ir[OP_MSB:OP_LSB] inside {OP_ADD, OP_ADDI};
    pc_jmp  = in_exec && br_cls && take_branch;
    pc_inc  = wr_en || (in_exec && (ill_cls || (br_cls && !take_branch)));
    retire  = wr_en || (in_exec && !wr_cls);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir       <= '0;
      res_q    <= '0;
      pc       <= '0;
      retired  <= '0;
      ovf_flag <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (instr_ready && instr_valid) ir <= instr;
      if (in_exec) res_q <= alu_result;
      if (in_exec && add_cls && alu_ovf) ovf_flag <= 1'b1;
      illegal <= in_exec && ill_cls;
      if (pc_jmp) pc <= pc + PC_W'($signed(imm_out));
      else if (pc_inc) pc <= pc + PC_W'(1);
      if (retire) retired <= retired + 16'd1;
    end
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb_alu_exec_sequencer: scoreboard bench for alu_exec_sequencer with directed vectors
module tb_alu_exec_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic instr_valid = 1'b0, instr_ready;
  logic [15:0] instr = '0, alu_result = '0;
  logic alu_ovf = 1'b0, take_branch = 1'b0;
  logic [2:0] rd0_addr, rd1_addr, wr_addr;
  logic [3:0] alu_op;
  logic alu_src1, alu_src2, wr_en, busy, halted, ovf_flag, illegal;
  logic [15:0] imm_out, wr_data, retired;
  logic [7:0] pc;

  alu_exec_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_result(alu_result), .alu_ovf(alu_ovf), .take_branch(take_branch),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .wr_addr(wr_addr), .alu_op(alu_op),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .imm_out(imm_out), .wr_en(wr_en),
    .wr_data(wr_data), .pc(pc), .busy(busy), .halted(halted), .ovf_flag(ovf_flag),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr, res;
    logic aovf, tkb, wr;
    logic [2:0] wa;
    logic [15:0] wd;
    logic [7:0] pc;
    logic [15:0] ret;
    logic ovf, ill, hlt;
    int lat;
    logic [3:0] op;
    logic s1, s2;
    logic [15:0] imm;
    logic [2:0] r0, r1;
  } exp_t;

  exp_t vec [12];
  exp_t q [$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, acc = -1;
  int wr_cnt = 0, wr_lat = 0;
  logic [2:0] wr_a;
  logic [15:0] wr_d;
  logic prev_busy = 1'b0, ill_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (instr_valid && instr_ready && !rst) acc = cyc;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (wr_en) begin
      wr_cnt++;
      wr_a = wr_addr;
      wr_d = wr_data;
      wr_lat = cyc - acc + 1;
    end
    if (ill_prev) chk("illegal_pulse_width", illegal, 0);
    ill_prev = illegal;
    if (busy && cyc == acc && q.size() > 0) begin
      e = q[0];
      chk("dec_alu_op", alu_op, e.op);
      chk("dec_src1", alu_src1, e.s1);
      chk("dec_src2", alu_src2, e.s2);
      chk("dec_imm", imm_out, e.imm);
      chk("dec_rd0", rd0_addr, e.r0);
      chk("dec_rd1", rd1_addr, e.r1);
      chk("dec_wr_addr", wr_addr, e.wa);
    end
    if (prev_busy && !busy) begin
      if (rst) wr_cnt = 0;
      else begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_completion: got done with empty scoreboard required none");
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc - acc, e.lat);
          chk("wr_en_cycles", wr_cnt, {31'b0, e.wr});
          if (e.wr) begin
            chk("wr_addr", wr_a, e.wa);
            chk("wr_data", wr_d, e.wd);
            chk("wr_latency", wr_lat, 3);
          end
          chk("pc", pc, e.pc);
          chk("retired", retired, e.ret);
          chk("ovf_flag", ovf_flag, e.ovf);
          chk("illegal", illegal, e.ill);
          chk("halted", halted, e.hlt);
        end
        wr_cnt = 0;
      end
    end
    prev_busy = busy;
  end

  task automatic issue(input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", n < 20, 1);
    instr = e.instr;
    alu_result = e.res;
    alu_ovf = e.aovf;
    take_branch = e.tkb;
    q.push_back(e);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("done_wait", n < 20, 1);
  endtask

  initial begin
    int n;
    //          instr     res       aovf tkb wr wa wd        pc  ret ovf ill hlt lat op    s1 s2 imm       r0 r1
    vec[0]  = '{16'h0650, 16'h0007, 0, 0, 1, 3, 16'h0007, 1,  1,  0, 0, 0, 3, 4'h0, 0, 0, 16'h0010, 1, 2};
    vec[1]  = '{16'hABFE, 16'hFFFE, 0, 0, 1, 5, 16'hFFFE, 2,  2,  0, 0, 0, 3, 4'h0, 1, 1, 16'hFFFE, 7, 7};
    vec[2]  = '{16'h6048, 16'h0000, 0, 1, 0, 0, 16'h0000, 10, 3,  0, 0, 0, 2, 4'h6, 0, 0, 16'h0008, 1, 1};
    vec[3]  = '{16'h70BC, 16'h0000, 0, 1, 0, 0, 16'h0000, 6,  4,  0, 0, 0, 2, 4'h7, 0, 0, 16'hFFFC, 2, 7};
    vec[4]  = '{16'h6004, 16'h0000, 0, 1, 0, 0, 16'h0000, 10, 5,  0, 0, 0, 2, 4'h6, 0, 0, 16'h0004, 0, 0};
    vec[5]  = '{16'h70BC, 16'h5555, 0, 0, 0, 0, 16'h0000, 11, 6,  0, 0, 0, 2, 4'h7, 0, 0, 16'hFFFC, 2, 7};
    vec[6]  = '{16'h84E0, 16'h1234, 1, 0, 1, 2, 16'h1234, 12, 7,  0, 0, 0, 3, 4'h8, 0, 0, 16'hFFE0, 3, 4};
    vec[7]  = '{16'h0848, 16'h8000, 1, 0, 1, 4, 16'h8000, 13, 8,  1, 0, 0, 3, 4'h0, 0, 0, 16'h0008, 1, 1};
    vec[8]  = '{16'h9D85, 16'h0009, 0, 0, 1, 6, 16'h0009, 14, 9,  1, 0, 0, 3, 4'h0, 0, 1, 16'h0005, 6, 0};
    vec[9]  = '{16'hB000, 16'h0000, 0, 0, 0, 0, 16'h0000, 15, 10, 1, 1, 0, 2, 4'hB, 0, 0, 16'h0000, 0, 0};
    vec[10] = '{16'h5298, 16'h0040, 0, 0, 1, 1, 16'h0040, 16, 11, 1, 0, 0, 3, 4'h5, 0, 0, 16'h0018, 2, 3};
    vec[11] = '{16'hF000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16, 12, 1, 0, 1, 2, 4'hF, 0, 0, 16'h0000, 0, 0};
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_illegal", illegal, 0);
    for (int i = 0; i < 12; i++) issue(vec[i]);
    instr = 16'h0650;
    instr_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("halt_ready", instr_ready, 0);
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_pc", pc, 16);
    end
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_pc", pc, 0);
    chk("rst2_ready", instr_ready, 1);
    chk("rst2_halted", halted, 0);
    chk("rst2_ovf", ovf_flag, 0);
    chk("rst2_retired", retired, 0);
    instr = 16'h0650;
    alu_result = 16'h0007;
    alu_ovf = 1'b0;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!wr_en && n < 10) begin @(negedge clk); n++; end
    chk("abort_reach_wb", wr_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_wr_en_drop", wr_en, 0);
    chk("abort_pc", pc, 0);
    chk("abort_retired", retired, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_wr_en", wr_en, 0);
    end
    chk("post_abort_pc", pc, 0);
    chk("post_abort_retired", retired, 0);
    chk("post_abort_ready", instr_ready, 1);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end
endmodule
